// File: rtl/priority_decoder_accum.sv
// -----------------------------------------------------------------------------
// priority_decoder_accum
//
// Consumer-side inverse of the iterative-scan 8-to-3 priority encoder.
// Encoded bit indices arrive one per beat over a valid/ready handshake. Each
// accepted index produces a one-cycle one-hot strobe and is ORed into a frame
// accumulator. On the frame's last beat, the rebuilt vector is offered on an
// output handshake and held until the consumer takes it.
//
// Optional feature (compile-time macro ORDER_CHECK_EN):
//   defined   - track the previous index of the frame and raise a sticky
//               order_err when a non-first beat is not strictly ascending
//   undefined - no order tracking; order_err is tied low
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   in_code     in   encoded bit index (0 = LSB)
//   in_last     in   final index of the current frame
//   in_valid    in   in_code/in_last valid
//   in_ready    out  block can accept a beat (low while rst is high)
//   onehot      out  registered strobe 1<<in_code, one cycle per accepted beat
//   mask        out  rebuilt vector of the most recently completed frame
//   mask_valid  out  mask offered; held until mask_ready
//   mask_ready  in   consumer takes mask
//   order_err   out  sticky frame-order error flag
// -----------------------------------------------------------------------------
module priority_decoder_accum #(
    parameter  int SEL_W = 3,
    localparam int OUT_W = 2**SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SEL_W-1:0] in_code,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] onehot,
    output logic [OUT_W-1:0] mask,
    output logic             mask_valid,
    input  logic             mask_ready,
    output logic             order_err
);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] acc_nxt;
    logic [OUT_W-1:0] mask_nxt;
    logic [OUT_W-1:0] onehot_nxt;
    logic [OUT_W-1:0] code_bit;
    logic             mask_valid_nxt;
    logic             accept;

    assign in_ready = (state == ACCUM) && !rst;
    assign accept   = in_valid && in_ready;
    assign code_bit = OUT_W'(1'b1) << in_code;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no branch
        // can leave one unassigned and infer a latch.
        state_nxt      = state;
        acc_nxt        = acc;
        mask_nxt       = mask;
        mask_valid_nxt = mask_valid;
        onehot_nxt     = accept ? code_bit : '0;

        case (state)
            ACCUM: begin
                if (accept) begin
                    if (in_last) begin
                        mask_nxt       = acc | code_bit;
                        mask_valid_nxt = 1'b1;
                        acc_nxt        = '0;
                        state_nxt      = HOLD;
                    end else begin
                        acc_nxt = acc | code_bit;
                    end
                end
            end
            HOLD: begin
                if (mask_ready) begin
                    mask_valid_nxt = 1'b0;
                    state_nxt      = ACCUM;
                end
            end
            default: state_nxt = ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ACCUM;
            acc        <= '0;
            onehot     <= '0;
            mask       <= '0;
            mask_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            acc        <= acc_nxt;
            onehot     <= onehot_nxt;
            mask       <= mask_nxt;
            mask_valid <= mask_valid_nxt;
        end
    end

`ifdef ORDER_CHECK_EN
    logic [SEL_W-1:0] prev;
    logic             first_beat;

    // Every accepted beat sets a bit in acc, so an empty accumulator means no
    // beat of the current frame has been accepted yet.
    assign first_beat = (acc == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev      <= '0;
            order_err <= 1'b0;
        end else if (accept) begin
            prev <= in_last ? '0 : in_code;
            if (first_beat) begin
                order_err <= 1'b0;
            end else if (in_code <= prev) begin
                order_err <= 1'b1;
            end
        end
    end
`else
    assign order_err = 1'b0;
`endif

endmodule

// File: tb/tb_priority_decoder_accum.sv
// -----------------------------------------------------------------------------
// tb_priority_decoder_accum
//
// Self-checking bench for priority_decoder_accum (SEL_W = 3). A frame-level
// reference model (queue of indices per frame, mask rebuilt by ORing the
// queue) predicts every output each cycle. Honours ORDER_CHECK_EN the same
// way the design does.
// -----------------------------------------------------------------------------
module tb_priority_decoder_accum;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] in_code;
    logic       in_last;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] onehot;
    logic [7:0] mask;
    logic       mask_valid;
    logic       mask_ready;
    logic       order_err;

    int n_vec = 0;
    int n_mis = 0;

    priority_decoder_accum #(.SEL_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_code    (in_code),
        .in_last    (in_last),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .onehot     (onehot),
        .mask       (mask),
        .mask_valid (mask_valid),
        .mask_ready (mask_ready),
        .order_err  (order_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int unsigned m_codes[$];        // indices of the frame in progress
    bit          m_hold   = 1'b0;   // rebuilt mask waiting for consumer
    bit          m_mv     = 1'b0;
    bit          m_err    = 1'b0;
    logic [7:0]  m_mask   = '0;
    logic [7:0]  m_onehot = '0;

`ifdef ORDER_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    // Apply one cycle of inputs, advance to 1 time unit after the edge, and
    // advance the model to match.
    task automatic tick(input logic r, input logic v, input logic [2:0] c,
                        input logic l, input logic mr);
        bit acc_ok;
        rst        = r;
        in_valid   = v;
        in_code    = c;
        in_last    = l;
        mask_ready = mr;
        acc_ok     = v && !m_hold && !r;
        @(posedge clk);
        #1;
        if (r) begin
            m_codes.delete();
            m_hold   = 1'b0;
            m_mv     = 1'b0;
            m_err    = 1'b0;
            m_mask   = '0;
            m_onehot = '0;
        end else begin
            m_onehot = acc_ok ? (8'h01 << c) : 8'h00;
            if (acc_ok) begin
                if (CHK) begin
                    if (m_codes.size() == 0)      m_err = 1'b0;
                    else if (c <= m_codes[$])     m_err = 1'b1;
                end
                m_codes.push_back(c);
                if (l) begin
                    m_mask = '0;
                    foreach (m_codes[i]) m_mask |= 8'h01 << m_codes[i];
                    m_codes.delete();
                    m_hold = 1'b1;
                    m_mv   = 1'b1;
                end
            end else if (m_hold && mr) begin
                m_hold = 1'b0;
                m_mv   = 1'b0;
            end
        end
    endtask

    // {in_ready, onehot, mask, mask_valid, order_err}
    function automatic logic [18:0] exp_vec();
        return {!m_hold && !rst, m_onehot, m_mask, m_mv, m_err};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {in_ready, onehot, mask, mask_valid, order_err};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            tick(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
            n_vec++;
            if (dut_vec() !== 19'h0) begin
                n_mis++;
                $display("FAIL reset[%0d]: got %h want %h", i, dut_vec(), 19'h0);
            end
        end
        tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        n_vec++;
        if (dut_vec() !== {1'b1, 18'h0}) begin
            n_mis++;
            $display("FAIL reset_release: got %h want %h", dut_vec(), {1'b1, 18'h0});
        end
    endtask

    task automatic test_frame();
        logic [2:0] codes [3] = '{3'd1, 3'd3, 3'd6};
        logic [7:0] exp_oh[3] = '{8'h02, 8'h08, 8'h40};
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, codes[i], i == 2, 1'b1);
            n_vec++;
            if (dut_vec() !== exp_vec() || onehot !== exp_oh[i]) begin
                n_mis++;
                $display("FAIL frame[%0d]: got %h want %h (onehot %h want %h)",
                         i, dut_vec(), exp_vec(), onehot, exp_oh[i]);
            end
        end
        n_vec++;
        if (mask !== 8'h4A || mask_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL frame_mask: got mask %h mv %b rdy %b want 4a 1 0",
                     mask, mask_valid, in_ready);
        end
        tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        n_vec++;
        if (dut_vec() !== exp_vec() || mask_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL frame_handoff: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_hold();
        tick(1'b0, 1'b1, 3'd7, 1'b1, 1'b0);
        n_vec++;
        if (dut_vec() !== exp_vec() || mask !== 8'h80) begin
            n_mis++;
            $display("FAIL hold_single: got %h want %h", dut_vec(), exp_vec());
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'b0);
            n_vec++;
            if (dut_vec() !== exp_vec() || mask !== 8'h80 || mask_valid !== 1'b1 ||
                in_ready !== 1'b0 || onehot !== 8'h00) begin
                n_mis++;
                $display("FAIL hold_stall[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        n_vec++;
        if (dut_vec() !== exp_vec() || mask !== 8'h80 || in_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL hold_release: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_duplicate();
        logic [2:0] codes[3] = '{3'd2, 3'd2, 3'd5};
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b1, codes[i], i == 2, 1'b0);
            n_vec++;
            if (dut_vec() !== exp_vec() || (i >= 1 && order_err !== CHK)) begin
                n_mis++;
                $display("FAIL dup[%0d]: got %h want %h (order_err %b want %b)",
                         i, dut_vec(), exp_vec(), order_err, CHK);
            end
        end
        n_vec++;
        if (mask !== 8'h24) begin
            n_mis++;
            $display("FAIL dup_mask: got %h want %h", mask, 8'h24);
        end
        tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
        // First beat of the next frame clears the sticky flag.
        tick(1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
        n_vec++;
        if (dut_vec() !== exp_vec() || order_err !== 1'b0) begin
            n_mis++;
            $display("FAIL dup_clear: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid();
        tick(1'b0, 1'b1, 3'd0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 3'd4, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 3'd6, 1'b1, 1'b0);
        n_vec++;
        if (dut_vec() !== 19'h0) begin
            n_mis++;
            $display("FAIL rst_mid: got %h want %h", dut_vec(), 19'h0);
        end
        tick(1'b0, 1'b1, 3'd3, 1'b1, 1'b0);
        n_vec++;
        if (dut_vec() !== exp_vec() || mask !== 8'h08) begin
            n_mis++;
            $display("FAIL rst_mid_mask: got %h want %h (mask %h want 08)",
                     dut_vec(), exp_vec(), mask);
        end
        tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [2:0] codes [4] = '{3'd0, 3'd1, 3'd1, 3'd1};
        logic [7:0] exp_msk[4] = '{8'h01, 8'h01, 8'h02, 8'h02};
        logic       exp_mv [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b1, codes[i], 1'b1, 1'b1);
            n_vec++;
            if (dut_vec() !== exp_vec() || mask !== exp_msk[i] || mask_valid !== exp_mv[i]) begin
                n_mis++;
                $display("FAIL b2b[%0d]: got %h want %h (mask %h mv %b want %h %b)",
                         i, dut_vec(), exp_vec(), mask, mask_valid, exp_msk[i], exp_mv[i]);
            end
        end
        tick(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            tick(1'($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 3) != 0),
                 3'($urandom_range(0, 7)),
                 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 1)));
            n_vec++;
            if (dut_vec() !== exp_vec()) begin
                n_mis++;
                $display("FAIL random[%0d]: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_hold();
        test_duplicate();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
